// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM encoding, default frame markers and checksum helper
package uart_frame_pkg;
  localparam int CHK_W = 8;
  localparam logic [7:0] DEF_START = 8'hA5;
  localparam logic [7:0] DEF_STOP = 8'h5A;
  localparam logic [3:0] S_IDLE = 4'd0, S_RX_SEL = 4'd1, S_RX_DATA = 4'd2, S_RX_CHK = 4'd3,
    S_RX_STOP = 4'd4, S_WAIT_TX = 4'd5, S_TX_START = 4'd6, S_TX_SEL = 4'd7,
    S_TX_DATA = 4'd8, S_TX_CHK = 4'd9, S_TX_STOP = 4'd10;
  function automatic logic [CHK_W-1:0] xor_bytes(input logic [63:0] v);
    logic [CHK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r ^ v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/uart_frame_ser.sv
// uart_frame_ser: holds up to NB bytes and presents them MSB first on a valid/ready byte port
module uart_frame_ser #(
  parameter int NB = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [8*NB-1:0]         data_i,
  input  logic [$clog2(NB+1)-1:0] nbytes_i,
  output logic [7:0]              tx_byte_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    empty_o,
  output logic                    last_o
);
  localparam int CW = $clog2(NB+1);
  logic [8*NB-1:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc;
  assign tx_valid_o = cnt_q != '0;
  assign tx_byte_o = hold_q[8*NB-1 -: 8];
  assign empty_o = ~tx_valid_o;
  assign acc = tx_valid_o & tx_ready_i;
  assign last_o = acc & (cnt_q == CW'(1));
  always_comb begin
    hold_d = (load_i && empty_o) ? data_i : acc ? hold_q << 8 : hold_q;
    cnt_d = (load_i && empty_o) ? nbytes_i : acc ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_q <= '0;
      cnt_q <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: receives a framed block of complex samples over a byte UART and
// returns a framed block of result coefficients
module uart_frame_ctrl import uart_frame_pkg::*; #(
  parameter int         SAMPLE_BYTES = 2,
  parameter int         LOG2_MAX_N   = 5,
  parameter logic [7:0] START_BYTE   = DEF_START,
  parameter logic [7:0] STOP_BYTE    = DEF_STOP,
  parameter int         TIMEOUT_CYC  = 1_000_000,
  localparam int        W            = 8*SAMPLE_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            tx_byte_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [W-1:0]          sample_re_o,
  output logic [W-1:0]          sample_im_o,
  output logic [LOG2_MAX_N-1:0] sample_idx_o,
  output logic                  sample_valid_o,
  output logic [LOG2_MAX_N:0]   n_points_o,
  output logic                  rx_done_o,
  output logic                  rx_error_o,
  input  logic                  tx_start_i,
  input  logic [W-1:0]          coeff_re_i,
  input  logic [W-1:0]          coeff_im_i,
  input  logic                  coeff_valid_i,
  output logic                  coeff_ready_o,
  output logic                  tx_done_o,
  output logic                  busy_o
);
  localparam int NB = 2*SAMPLE_BYTES;
  localparam int BW = $clog2(NB);
  localparam int CW = $clog2(NB+1);
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam int NW = LOG2_MAX_N+1;
  localparam logic [8*NB-9:0] PAD = '0;
  logic [3:0] st_q, st_d;
  logic [7:0] k_q, k_d;
  logic [NW-1:0] n_q, n_d;
  logic [LOG2_MAX_N-1:0] scnt_q, scnt_d, sidx_q, sidx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2*W-9:0] sh_q, sh_d;
  logic [W-1:0] re_q, re_d, im_q, im_d;
  logic [CHK_W-1:0] chk_q, chk_d, txc_q, txc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic sv_q, sv_d, done_q, done_d, err_q, err_d;
  logic [2*W-1:0] full;
  logic rx_act, tmo_hit, last_s, hs;
  logic ser_ld, ser_empty, ser_last;
  logic [8*NB-1:0] ser_data;
  logic [CW-1:0] ser_nb;
  assign full = {sh_q, rx_byte_i};
  assign rx_act = st_q >= S_RX_SEL && st_q <= S_RX_STOP;
  assign tmo_hit = rx_act & ~rx_valid_i & (tmo_q == TW'(TIMEOUT_CYC-1));
  assign last_s = {1'b0, scnt_q} == n_q - NW'(1);
  assign coeff_ready_o = (st_q == S_TX_DATA) & ser_empty;
  assign hs = coeff_valid_i & coeff_ready_o;
  assign tx_done_o = (st_q == S_TX_STOP) & ser_last;
  assign busy_o = st_q != S_IDLE;
  assign sample_re_o = re_q;
  assign sample_im_o = im_q;
  assign sample_idx_o = sidx_q;
  assign sample_valid_o = sv_q;
  assign n_points_o = n_q;
  assign rx_done_o = done_q;
  assign rx_error_o = err_q;
  always_comb begin
    st_d = st_q;
    k_d = k_q;
    n_d = n_q;
    scnt_d = scnt_q;
    bcnt_d = bcnt_q;
    sh_d = sh_q;
    re_d = re_q;
    im_d = im_q;
    sidx_d = sidx_q;
    chk_d = chk_q;
    txc_d = txc_q;
    sv_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    ser_ld = 1'b0;
    ser_data = '0;
    ser_nb = CW'(1);
    tmo_d = (rx_act && !rx_valid_i) ? tmo_q + TW'(1) : '0;
    case (st_q)
      S_IDLE: if (rx_valid_i && rx_byte_i == START_BYTE) begin
        st_d = S_RX_SEL;
        chk_d = '0;
      end
      S_RX_SEL: if (rx_valid_i) begin
        if (rx_byte_i >= 8'd3 && rx_byte_i <= 8'(LOG2_MAX_N)) begin
          st_d = S_RX_DATA;
          k_d = rx_byte_i;
          n_d = NW'(1) << rx_byte_i;
          chk_d = rx_byte_i;
          scnt_d = '0;
          bcnt_d = '0;
        end else begin
          st_d = S_IDLE;
          err_d = 1'b1;
        end
      end
      S_RX_DATA: if (rx_valid_i) begin
        chk_d = chk_q ^ rx_byte_i;
        sh_d = full[2*W-9:0];
        bcnt_d = bcnt_q + BW'(1);
        if (bcnt_q == BW'(NB-1)) begin
          bcnt_d = '0;
          re_d = full[2*W-1:W];
          im_d = full[W-1:0];
          sidx_d = scnt_q;
          sv_d = 1'b1;
          scnt_d = scnt_q + 1'b1;
          st_d = last_s ? S_RX_CHK : S_RX_DATA;
        end
      end
      S_RX_CHK: if (rx_valid_i) begin
        st_d = rx_byte_i == chk_q ? S_RX_STOP : S_IDLE;
        err_d = rx_byte_i != chk_q;
      end
      S_RX_STOP: if (rx_valid_i) begin
        st_d = rx_byte_i == STOP_BYTE ? S_WAIT_TX : S_IDLE;
        done_d = rx_byte_i == STOP_BYTE;
        err_d = rx_byte_i != STOP_BYTE;
      end
      S_WAIT_TX: if (tx_start_i) st_d = S_TX_START;
      S_TX_START: begin
        ser_ld = 1'b1;
        ser_data = {START_BYTE, PAD};
        txc_d = k_q;
        if (ser_last) st_d = S_TX_SEL;
      end
      S_TX_SEL: begin
        ser_ld = 1'b1;
        ser_data = {k_q, PAD};
        scnt_d = '0;
        if (ser_last) st_d = S_TX_DATA;
      end
      S_TX_DATA: begin
        ser_ld = hs;
        ser_data = {coeff_re_i, coeff_im_i};
        ser_nb = CW'(NB);
        if (hs) txc_d = txc_q ^ xor_bytes(64'(coeff_re_i)) ^ xor_bytes(64'(coeff_im_i));
        if (ser_last) begin
          scnt_d = scnt_q + 1'b1;
          st_d = last_s ? S_TX_CHK : S_TX_DATA;
        end
      end
      S_TX_CHK: begin
        ser_ld = 1'b1;
        ser_data = {txc_q, PAD};
        if (ser_last) st_d = S_TX_STOP;
      end
      S_TX_STOP: begin
        ser_ld = 1'b1;
        ser_data = {STOP_BYTE, PAD};
        if (ser_last) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      st_d = S_IDLE;
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= S_IDLE;
      k_q <= '0;
      n_q <= '0;
      scnt_q <= '0;
      bcnt_q <= '0;
      sh_q <= '0;
      re_q <= '0;
      im_q <= '0;
      sidx_q <= '0;
      chk_q <= '0;
      txc_q <= '0;
      tmo_q <= '0;
      sv_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      k_q <= k_d;
      n_q <= n_d;
      scnt_q <= scnt_d;
      bcnt_q <= bcnt_d;
      sh_q <= sh_d;
      re_q <= re_d;
      im_q <= im_d;
      sidx_q <= sidx_d;
      chk_q <= chk_d;
      txc_q <= txc_d;
      tmo_q <= tmo_d;
      sv_q <= sv_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  uart_frame_ser #(.NB(NB)) u_ser (
    .clk(clk),
    .rst(rst),
    .load_i(ser_ld),
    .data_i(ser_data),
    .nbytes_i(ser_nb),
    .tx_byte_o(tx_byte_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .empty_o(ser_empty),
    .last_o(ser_last)
  );
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed frames through RX and TX paths with hand-computed expectations
`timescale 1ns/1ps
module tb_uart_frame_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_byte_i = '0, tx_byte_o;
  logic rx_valid_i = 1'b0, tx_valid_o, tx_ready_i = 1'b0;
  logic [15:0] sample_re_o, sample_im_o, coeff_re_i, coeff_im_i;
  logic [4:0] sample_idx_o;
  logic [5:0] n_points_o;
  logic sample_valid_o, rx_done_o, rx_error_o, tx_start_i = 1'b0, coeff_valid_i = 1'b0;
  logic coeff_ready_o, tx_done_o, busy_o;
  int n_chk = 0, n_fail = 0;
  int sv_cnt = 0, done_cnt = 0, err_cnt = 0, txd_cnt = 0, tx_cnt = 0, cidx = 0;
  logic [4:0] mon_idx [512];
  logic [15:0] mon_re [512];
  logic [15:0] mon_im [512];
  logic [7:0] tx_log [64];
  uart_frame_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i),
    .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .sample_re_o(sample_re_o), .sample_im_o(sample_im_o), .sample_idx_o(sample_idx_o),
    .sample_valid_o(sample_valid_o), .n_points_o(n_points_o), .rx_done_o(rx_done_o),
    .rx_error_o(rx_error_o), .tx_start_i(tx_start_i), .coeff_re_i(coeff_re_i),
    .coeff_im_i(coeff_im_i), .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o),
    .tx_done_o(tx_done_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  assign coeff_re_i = {8'(cidx*3), 8'h11};
  assign coeff_im_i = 16'h2280;
  always @(posedge clk) if (coeff_valid_i && coeff_ready_o) cidx <= cidx + 1;
  always @(negedge clk) begin
    if (sample_valid_o) begin
      mon_idx[sv_cnt] = sample_idx_o;
      mon_re[sv_cnt] = sample_re_o;
      mon_im[sv_cnt] = sample_im_o;
      sv_cnt++;
    end
    if (rx_done_o) done_cnt++;
    if (rx_error_o) err_cnt++;
    if (tx_done_o) txd_cnt++;
    if (tx_valid_o && tx_ready_i && tx_cnt < 64) begin
      tx_log[tx_cnt] = tx_byte_o;
      tx_cnt++;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte_i = b;
    rx_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] k, input logic [15:0] rb, input logic [15:0] ib,
                            input logic [15:0] stp, input logic [7:0] flip, input bit with_stop);
    logic [7:0] c;
    logic [15:0] r, m;
    c = k;
    send(8'hA5);
    send(k);
    for (int i = 0; i < (1 << k); i++) begin
      r = rb + stp * 16'(i);
      m = ib + stp * 16'(i);
      send(r[15:8]); send(r[7:0]); send(m[15:8]); send(m[7:0]);
      c = c ^ r[15:8] ^ r[7:0] ^ m[15:8] ^ m[7:0];
    end
    send(c ^ flip);
    if (with_stop) send(8'h5A);
  endtask
  task automatic check_samples(input string tag, input int base, input int n,
                               input logic [15:0] rb, input logic [15:0] ib, input logic [15:0] stp);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++)
      if (mon_idx[base+i] !== 5'(i) || mon_re[base+i] !== rb + stp * 16'(i) ||
          mon_im[base+i] !== ib + stp * 16'(i)) ok = 1'b0;
    check(tag, 64'(ok), 64'd1);
  endtask
  function automatic logic [63:0] outs();
    return 64'({tx_byte_o, tx_valid_o, sample_re_o, sample_im_o, sample_idx_o, sample_valid_o,
                n_points_o, rx_done_o, rx_error_o, coeff_ready_o, tx_done_o, busy_o});
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int sb, db, eb, tb0, n;
    logic [7:0] exp_tx [36];
    logic [7:0] c;
    idle(3);
    check("reset_outputs", outs(), 64'd0);
    rst = 1'b0;
    idle(1);
    sb = sv_cnt; db = done_cnt; eb = err_cnt;
    send_frame(8'h03, 16'h0100, 16'hFF00, 16'h0000, 8'h00, 1'b1);
    idle(2);
    check("frame_sv_count", sv_cnt - sb, 8);
    check_samples("frame_samples", sb, 8, 16'h0100, 16'hFF00, 16'h0000);
    check("frame_n_points", n_points_o, 8);
    check("frame_done", done_cnt - db, 1);
    check("frame_no_err", err_cnt - eb, 0);
    check("wait_tx_busy", busy_o, 1);
    send(8'hA5); send(8'h03); send(8'h00);
    idle(2);
    check("wait_rx_ignored", sv_cnt - sb + err_cnt - eb, 8);
    tb0 = tx_cnt; db = txd_cnt;
    exp_tx[0] = 8'hA5; exp_tx[1] = 8'h03; c = 8'h03;
    for (int k = 0; k < 8; k++) begin
      exp_tx[2+4*k] = 8'(k*3); exp_tx[3+4*k] = 8'h11; exp_tx[4+4*k] = 8'h22; exp_tx[5+4*k] = 8'h80;
      c = c ^ 8'(k*3) ^ 8'h11 ^ 8'h22 ^ 8'h80;
    end
    exp_tx[34] = c; exp_tx[35] = 8'h5A;
    check("tx_chk_model", c, 8'h0B);
    tx_start_i = 1'b1; coeff_valid_i = 1'b1;
    for (int i = 0; i < 3000 && txd_cnt == db; i++) begin
      @(posedge clk); #1;
      if (i % 3 == 2) tx_ready_i = ~tx_ready_i;
    end
    tx_start_i = 1'b0; coeff_valid_i = 1'b0; tx_ready_i = 1'b0;
    idle(1);
    check("tx_done_count", txd_cnt - db, 1);
    check("tx_byte_count", tx_cnt - tb0, 36);
    for (int i = 0; i < 36; i++) check("tx_byte", tx_log[(tb0+i) % 64], exp_tx[i]);
    check("coeff_taken", cidx, 8);
    check("tx_idle", busy_o, 0);
    sb = sv_cnt; eb = err_cnt;
    send(8'hA5); send(8'h06);
    check("sel6_err_pulse", rx_error_o, 1);
    idle(2);
    check("sel6_idle", busy_o, 0);
    send(8'hA5); send(8'h02);
    check("sel2_err_pulse", rx_error_o, 1);
    idle(2);
    check("badsel_err_count", err_cnt - eb, 2);
    check("badsel_no_samples", sv_cnt - sb, 0);
    sb = sv_cnt; db = done_cnt; eb = err_cnt;
    send_frame(8'h03, 16'h1234, 16'h8001, 16'h0101, 8'h01, 1'b0);
    check("badchk_err_pulse", rx_error_o, 1);
    send(8'h5A);
    idle(2);
    check("badchk_no_done", done_cnt - db, 0);
    check("badchk_err_count", err_cnt - eb, 1);
    check("badchk_sv_count", sv_cnt - sb, 8);
    check("badchk_idle", busy_o, 0);
    send(8'hA5); send(8'h03); send(8'h01); send(8'h02);
    n = 0;
    while (n < 300 && !rx_error_o) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", 64'(n >= 100 && n <= 101), 64'd1);
    check("timeout_idle", busy_o, 0);
    @(posedge clk); #1;
    send(8'hA5);
    check("restart_accepted", busy_o, 1);
    sb = sv_cnt; db = done_cnt; eb = err_cnt;
    send(8'h03);
    for (int i = 0; i < 3; i++) begin
      send(8'h44); send(8'(8'h40 + i)); send(8'h55); send(8'(8'h50 + i));
    end
    send(8'h44); send(8'h43);
    rst = 1'b1;
    #1;
    check("midreset_outputs", outs(), 64'd0);
    check("midreset_sv_before", sv_cnt - sb, 3);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("midreset_no_pulse", (done_cnt - db) + (err_cnt - eb), 0);
    check("midreset_idle", busy_o, 0);
    sb = sv_cnt; db = done_cnt;
    send_frame(8'h04, 16'h0A00, 16'h0B00, 16'h0003, 8'h00, 1'b1);
    idle(2);
    check("n16_sv_count", sv_cnt - sb, 16);
    check_samples("n16_samples", sb, 16, 16'h0A00, 16'h0B00, 16'h0003);
    check("n16_n_points", n_points_o, 16);
    check("n16_done", done_cnt - db, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    sb = sv_cnt; db = done_cnt; eb = err_cnt;
    send_frame(8'h05, 16'h7FF0, 16'h8000, 16'h0001, 8'h00, 1'b1);
    idle(2);
    check("n32_sv_count", sv_cnt - sb, 32);
    check_samples("n32_samples", sb, 32, 16'h7FF0, 16'h8000, 16'h0001);
    check("n32_n_points", n_points_o, 32);
    check("n32_done", done_cnt - db, 1);
    check("n32_no_err", err_cnt - eb, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
